fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
Parameters:
- REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits (legal range >= 1).
- REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the clock cycles per serial bit (legal range >= 1).

Ports:
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-005 The block SHALL have port enable, input, 1 bit: when high, the block may pop words from the upstream FIFO.
- REQ-006 The block SHALL have port empty, input, 1 bit: the empty flag of the upstream FIFO.
- REQ-007 The block SHALL have port rd_e, output, 1 bit: the read enable to the upstream FIFO.
- REQ-008 The block SHALL have port rd_data, input, WIDTH bits: the FIFO read word, valid in the cycle after the cycle in which rd_e is high (1-cycle read latency).
- REQ-009 The block SHALL have port tx, output, 1 bit: the serial line, idle high.
- REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
- REQ-011 The block SHALL have port tx_done, output, 1 bit: a one-cycle pulse in the last cycle of each stop bit.

Function
- REQ-012 The state machine SHALL have states IDLE, POP, LATCH, START, DATA and STOP; all outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.
- REQ-013 IDLE SHALL go to POP when enable=1 and empty=0, and SHALL otherwise hold IDLE; in IDLE, tx=1 and rd_e=0.
- REQ-014 rd_e SHALL be high only in POP, for exactly one cycle per word; POP SHALL go to LATCH unconditionally.
- REQ-015 LATCH SHALL capture rd_data into a WIDTH-bit shift register at the end of the cycle and go to START; in POP and LATCH, tx=1.
- REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- REQ-017 DATA SHALL drive tx = shift register bit 0 (LSB first) for CLKS_PER_BIT cycles per bit, shifting right after each bit, for WIDTH bits, then go to STOP.
- REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, with tx_done=1 in the last of those cycles.
- REQ-019 At the end of STOP, the next state SHALL be POP if enable=1 and empty=0, otherwise IDLE.
- REQ-020 Frame length from START entry to STOP exit SHALL be (WIDTH+2)*CLKS_PER_BIT cycles; back-to-back frames SHALL have exactly 2 extra tx=1 cycles (POP, LATCH) between the stop bit and the next start bit.
- REQ-021 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the bit counter SHALL count 0..WIDTH-1; each counter's width SHALL be clog2 of its range, minimum 1 bit.
- REQ-022 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle, with no skipped or doubled bits.
- REQ-023 Deasserting enable mid-frame SHALL NOT abort the frame: the frame completes and no further pop occurs.
- REQ-024 empty SHALL be sampled only in IDLE and in the last STOP cycle; empty changes during other states SHALL have no effect.
- REQ-025 rd_e SHALL NEVER be asserted while empty=1 was sampled, and never more than once per frame.

Reset
- REQ-026 On rst=1, regardless of clk, the block SHALL enter IDLE with tx=1, rd_e=0, busy=0, tx_done=0, and counters and shift register at 0.
- REQ-027 On reset mid-frame, the word in flight SHALL be discarded and not retransmitted.
- REQ-028 The first pop after reset deassertion SHALL occur no earlier than the first rising edge at which enable=1 and empty=0.

Verification
- REQ-029 Single word (WIDTH=8, CLKS_PER_BIT=4), FIFO holding 0xA5, enable=1 -> rd_e high 1 cycle; tx sequence 0,1,0,1,0,0,1,0,1,1 at 4 cycles each (40 cycles); tx_done pulses once; busy returns to 0.
- REQ-030 Back-to-back, FIFO holding 0x01 then 0x80 -> two frames with exactly 2 idle-high cycles between the first stop bit and the second start bit; 2 rd_e pulses total.
- REQ-031 Empty or disabled: empty=1 with enable=1, and separately empty=0 with enable=0, for 50 cycles -> rd_e=0, tx=1 and busy=0 throughout.
- REQ-032 Enable drop: enable falls during DATA with 3 words queued -> the current frame completes intact; no further rd_e; IDLE is reached.
- REQ-033 Reset mid-frame: rst pulses during the 3rd data bit, asynchronously between edges -> tx=1 and busy=0 immediately; after release with a non-empty FIFO, the next frame starts with the next FIFO word.
- REQ-034 Edge parameters: WIDTH=2, CLKS_PER_BIT=1, FIFO holding 2'b10, 2'b01, 2'b11, 2'b10 -> four 4-cycle frames, LSB first, each separated by 2 idle cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Pops words from a 1-cycle-latency FIFO and sends each as an 8N1-style UART frame
// (start bit, WIDTH data bits LSB first, one stop bit). All outputs are registered.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             empty,
    output logic             rd_e,
    input  logic [WIDTH-1:0] rd_data,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PEN  = BAUD_W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_reg;
    logic [BAUD_W-1:0]  baud_reg;
    logic [BIT_W-1:0]   bit_reg;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   shift_next;

    assign shift_next = shift_reg >> 1;

    // Outputs are assigned alongside each transition so they reflect the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            rd_e      <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable && !empty) begin
                        state_reg <= POP;
                        rd_e      <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                POP: begin
                    state_reg <= LATCH;
                    rd_e      <= 1'b0;
                end

                LATCH: begin
                    shift_reg <= rd_data;
                    baud_reg  <= '0;
                    state_reg <= START;
                    tx        <= 1'b0;
                end

                START: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg  <= '0;
                        bit_reg   <= '0;
                        state_reg <= DATA;
                        tx        <= shift_reg[0];
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg  <= '0;
                        shift_reg <= shift_next;
                        if (bit_reg == BIT_LAST) begin
                            state_reg <= STOP;
                            tx        <= 1'b1;
                            tx_done   <= (CLKS_PER_BIT == 1);
                        end else begin
                            bit_reg <= bit_reg + 1'b1;
                            tx      <= shift_next[0];
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_reg == BAUD_LAST) begin
                        baud_reg <= '0;
                        tx_done  <= 1'b0;
                        // empty is only consulted here and in IDLE, so a pop never races a frame.
                        if (enable && !empty) begin
                            state_reg <= POP;
                            rd_e      <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                        tx_done  <= (baud_reg == BAUD_PEN);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    tx        <= 1'b1;
                    rd_e      <= 1'b0;
                    busy      <= 1'b0;
                    tx_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-based FIFO models feed two instances (8/4 and 2/1);
// captured serial traces are decoded and compared with the words pushed.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;

    logic       enable_a = 1'b0;
    logic       empty_a  = 1'b1;
    logic       rd_e_a, tx_a, busy_a, tx_done_a;
    logic [7:0] rd_data_a = '0;

    logic       enable_b = 1'b0;
    logic       empty_b  = 1'b1;
    logic       rd_e_b, tx_b, busy_b, tx_done_b;
    logic [1:0] rd_data_b = '0;

    logic [7:0]  fifo_a[$];
    logic [1:0]  fifo_b[$];
    logic [31:0] exp_q[$];
    logic        tx_log[$], rd_log[$], done_log[$], busy_log[$];
    bit          logging = 1'b0;
    bit          mon_b   = 1'b0;

    int total = 0;
    int bad   = 0;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .enable(enable_a), .empty(empty_a), .rd_e(rd_e_a),
        .rd_data(rd_data_a), .tx(tx_a), .busy(busy_a), .tx_done(tx_done_a)
    );

    fifo_uart_tx #(.WIDTH(2), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .empty(empty_b), .rd_e(rd_e_b),
        .rd_data(rd_data_b), .tx(tx_b), .busy(busy_b), .tx_done(tx_done_b)
    );

    // FIFO models with one cycle of read latency
    always @(posedge clk) begin
        if (rd_e_a && fifo_a.size() > 0) rd_data_a <= fifo_a.pop_front();
        empty_a <= (fifo_a.size() == 0);
    end

    always @(posedge clk) begin
        if (rd_e_b && fifo_b.size() > 0) rd_data_b <= fifo_b.pop_front();
        empty_b <= (fifo_b.size() == 0);
    end

    always @(negedge clk) begin
        if (logging) begin
            tx_log.push_back(mon_b ? tx_b : tx_a);
            rd_log.push_back(mon_b ? rd_e_b : rd_e_a);
            done_log.push_back(mon_b ? tx_done_b : tx_done_a);
            busy_log.push_back(mon_b ? busy_b : busy_a);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        tx_log.delete();
        rd_log.delete();
        done_log.delete();
        busy_log.delete();
    endtask

    task automatic push_a(input logic [7:0] w, input bit expect_it);
        fifo_a.push_back(w);
        if (expect_it) exp_q.push_back(32'(w));
    endtask

    task automatic push_b(input logic [1:0] w);
        fifo_b.push_back(w);
        exp_q.push_back(32'(w));
    endtask

    task automatic wait_start_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_a === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (!ok) check_eq("start_timeout", 32'd0, 32'd1);
    endtask

    // Decode the captured trace frame by frame against the expected words.
    task automatic analyze(input int w, input int c, input bit b2b, input string name);
        int flen, nw, pos, start, prev_end, n_done, n_rd, glitch, done_err, b;
        logic [31:0] word, want;
        logic lvl;
        flen = (w + 2) * c;
        nw = exp_q.size();
        pos = 0;
        prev_end = 0;
        n_done = 0;
        n_rd = 0;
        foreach (tx_log[i]) begin
            if (done_log[i] === 1'b1) n_done++;
            if (rd_log[i] === 1'b1) n_rd++;
        end
        for (int f = 0; f < nw; f++) begin
            want = exp_q[f];
            start = -1;
            for (int i = pos; i < tx_log.size(); i++) begin
                if (tx_log[i] === 1'b0) begin
                    start = i;
                    break;
                end
            end
            if (start < 0 || start + flen > tx_log.size()) begin
                check_eq({name, "_frames_seen"}, 32'(f), 32'(nw));
                break;
            end
            if (b2b && f > 0) check_eq({name, "_gap"}, 32'(start - prev_end), 32'd2);
            glitch = 0;
            done_err = 0;
            word = '0;
            for (int k = 0; k < flen; k++) begin
                b = k / c;
                if (b == 0) lvl = 1'b0;
                else if (b <= w) lvl = want[b-1];
                else lvl = 1'b1;
                if (tx_log[start+k] !== lvl) glitch++;
                if (b >= 1 && b <= w && (k % c) == c / 2) word[b-1] = tx_log[start+k];
                if (done_log[start+k] !== (k == flen - 1)) done_err++;
            end
            check_eq({name, "_word"}, word, want);
            check_eq({name, "_bit_timing"}, 32'(glitch), 32'd0);
            check_eq({name, "_tx_done_pos"}, 32'(done_err), 32'd0);
            $display("frame %s #%0d: word=%0h expected=%0h start=%0d", name, f, word, want, start);
            prev_end = start + flen;
            pos = prev_end;
        end
        check_eq({name, "_tx_done_count"}, 32'(n_done), 32'(nw));
        check_eq({name, "_rd_e_count"}, 32'(n_rd), 32'(nw));
        check_eq({name, "_end_busy"}, 32'(busy_log[busy_log.size()-1]), 32'd0);
        check_eq({name, "_end_tx"}, 32'(tx_log[tx_log.size()-1]), 32'd1);
        exp_q.delete();
    endtask

    task automatic quiet_check(input string name);
        int n_rd, n_busy, n_low;
        n_rd = 0;
        n_busy = 0;
        n_low = 0;
        foreach (tx_log[i]) begin
            if (rd_log[i] !== 1'b0) n_rd++;
            if (busy_log[i] !== 1'b0) n_busy++;
            if (tx_log[i] !== 1'b1) n_low++;
        end
        check_eq({name, "_rd_e"}, 32'(n_rd), 32'd0);
        check_eq({name, "_busy"}, 32'(n_busy), 32'd0);
        check_eq({name, "_tx_low"}, 32'(n_low), 32'd0);
        $display("quiet %s: cycles=%0d rd_e=%0d busy=%0d tx_low=%0d", name, tx_log.size(), n_rd, n_busy, n_low);
    endtask

    task automatic capture(input int cycles);
        clear_log();
        logging = 1'b1;
        step(cycles);
        logging = 1'b0;
    endtask

    initial begin
        bit ok;

        // Reset state
        step(2);
        check_eq("reset_tx", 32'(tx_a), 32'd1);
        check_eq("reset_rd_e", 32'(rd_e_a), 32'd0);
        check_eq("reset_busy", 32'(busy_a), 32'd0);
        check_eq("reset_tx_done", 32'(tx_done_a), 32'd0);
        check_eq("reset_b_tx", 32'(tx_b), 32'd1);
        check_eq("reset_b_busy", 32'(busy_b), 32'd0);
        rst = 1'b0;
        step(2);

        // Single word 0xA5
        mon_b = 1'b0;
        push_a(8'hA5, 1'b1);
        enable_a = 1'b1;
        capture(70);
        enable_a = 1'b0;
        analyze(8, 4, 1'b0, "single");

        // Back-to-back 0x01, 0x80
        push_a(8'h01, 1'b1);
        push_a(8'h80, 1'b1);
        enable_a = 1'b1;
        capture(2 * 42 + 20);
        enable_a = 1'b0;
        analyze(8, 4, 1'b1, "b2b");

        // Randomized back-to-back burst
        for (int i = 0; i < 5; i++) push_a(8'($urandom_range(0, 255)), 1'b1);
        enable_a = 1'b1;
        capture(5 * 42 + 20);
        enable_a = 1'b0;
        analyze(8, 4, 1'b1, "rand_a");

        // Empty with enable, then non-empty with enable low
        enable_a = 1'b1;
        capture(50);
        quiet_check("empty");
        enable_a = 1'b0;
        for (int i = 0; i < 3; i++) push_a(8'($urandom_range(0, 255)), 1'b0);
        capture(50);
        quiet_check("disabled");
        fifo_a.delete();
        step(2);

        // Enable drops during the data phase
        push_a(8'($urandom_range(0, 255)), 1'b1);
        push_a(8'($urandom_range(0, 255)), 1'b0);
        push_a(8'($urandom_range(0, 255)), 1'b0);
        clear_log();
        enable_a = 1'b1;
        logging = 1'b1;
        wait_start_a(ok);
        step(8);
        enable_a = 1'b0;
        step(3 * 42);
        logging = 1'b0;
        analyze(8, 4, 1'b0, "en_drop");
        fifo_a.delete();
        step(2);

        // Asynchronous reset during the third data bit
        push_a(8'($urandom_range(0, 255)), 1'b0);
        push_a(8'($urandom_range(0, 255)), 1'b1);
        push_a(8'($urandom_range(0, 255)), 1'b1);
        enable_a = 1'b1;
        wait_start_a(ok);
        step(13);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_tx", 32'(tx_a), 32'd1);
        check_eq("async_rst_busy", 32'(busy_a), 32'd0);
        check_eq("async_rst_rd_e", 32'(rd_e_a), 32'd0);
        #2;
        rst = 1'b0;
        capture(2 * 42 + 20);
        enable_a = 1'b0;
        analyze(8, 4, 1'b1, "post_rst");
        fifo_a.delete();
        step(2);

        // Narrow instance, one clock per bit
        mon_b = 1'b1;
        push_b(2'b10);
        push_b(2'b01);
        push_b(2'b11);
        push_b(2'b10);
        enable_b = 1'b1;
        capture(4 * 6 + 20);
        enable_b = 1'b0;
        analyze(2, 1, 1'b1, "edge");

        for (int i = 0; i < 6; i++) push_b(2'($urandom_range(0, 3)));
        enable_b = 1'b1;
        capture(6 * 6 + 20);
        enable_b = 1'b0;
        analyze(2, 1, 1'b1, "rand_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
